// File: rtl/fib_seq_gen.sv
// +-----------------------------------------------------------------------------+
// | fib_seq_gen: two-term recurrence (a,b) <- (b,a+b) with seed load, wrap or  |
// | saturate arithmetic, sticky overflow, term index and N-term burst mode.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fib_seq_gen #(
  parameter int              WIDTH = 8,
  parameter int              CNT_W = 8,
  parameter logic [WIDTH-1:0] SEED0 = '0,
  parameter logic [WIDTH-1:0] SEED1 = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic             step,
  input  logic             sat_mode,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] index,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic             advance;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    index_d     = index_q;
    remaining_d = remaining_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    advance     = 1'b0;

    if (load) begin
      // Load also aborts a running burst; done stays low.
      a_d     = seed0;
      b_d     = seed1;
      index_d = '0;
      ovf_d   = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (n_terms != '0) begin
              remaining_d = n_terms;
              state_d     = RUN;
            end else begin
              done_d = 1'b1;
            end
          end else if (step) begin
            advance = 1'b1;
          end
        end
        RUN: begin
          advance     = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (advance) begin
      a_d = b_q;
      if (sum[WIDTH]) begin
        b_d   = sat_mode ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        ovf_d = 1'b1;
      end else begin
        b_d = sum[WIDTH-1:0];
      end
      if (index_q != {CNT_W{1'b1}}) begin
        index_d = index_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= SEED0;
      b_q         <= SEED1;
      index_q     <= '0;
      remaining_q <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      index_q     <= index_d;
      remaining_q <= remaining_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign out   = a_q;
  assign index = index_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fib_seq_gen.sv
// +-----------------------------------------------------------------------------+
// | tb_fib_seq_gen: directed self-checking bench for fib_seq_gen (WIDTH=8).    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_fib_seq_gen;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] seed0;
  logic [7:0] seed1;
  logic       step;
  logic       sat_mode;
  logic       start;
  logic [7:0] n_terms;
  logic [7:0] out;
  logic [7:0] index;
  logic       ovf;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  fib_seq_gen #(
    .WIDTH(8),
    .CNT_W(8),
    .SEED0(8'd0),
    .SEED1(8'd1)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .seed0   (seed0),
    .seed1   (seed1),
    .step    (step),
    .sat_mode(sat_mode),
    .start   (start),
    .n_terms (n_terms),
    .out     (out),
    .index   (index),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int fib_exp [13] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};
  int lucas_exp [5] = '{1, 3, 4, 7, 11};

  initial begin
    rst = 1'b1; load = 1'b0; seed0 = '0; seed1 = '0; step = 1'b0;
    sat_mode = 1'b0; start = 1'b0; n_terms = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out",   out,   0);
    chk("rst_index", index, 0);
    chk("rst_ovf",   ovf,   0);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);

    // Wrapping Fibonacci run
    step = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("fib_out%0d", i), out, fib_exp[i]);
    end
    chk("fib_index12", index, 12);
    chk("fib_ovf12",   ovf,   0);
    tick();
    chk("wrap_out13", out, 233);
    chk("wrap_ovf13", ovf, 1);
    tick();
    chk("wrap_out14", out, 121);
    chk("wrap_ovf14", ovf, 1);
    step = 1'b0;

    // Saturating run from reset
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_ovf", ovf, 0);
    sat_mode = 1'b1;
    step = 1'b1;
    for (int i = 1; i <= 12; i++) tick();
    chk("sat_out12", out, 144);
    tick();
    chk("sat_out13", out, 233);
    chk("sat_ovf13", ovf, 1);
    tick();
    chk("sat_out14", out, 255);
    tick();
    chk("sat_out15", out, 255);
    tick();
    chk("sat_out16", out, 255);
    chk("sat_index16", index, 16);
    step = 1'b0;
    sat_mode = 1'b0;

    // Load seeds 2,1 then burst of 5 with step held high throughout
    load = 1'b1; seed0 = 8'd2; seed1 = 8'd1;
    tick();
    load = 1'b0;
    chk("load_out",   out,   2);
    chk("load_index", index, 0);
    chk("load_ovf",   ovf,   0);
    start = 1'b1; n_terms = 8'd5; step = 1'b1;
    tick();
    start = 1'b0;
    chk("acc_out",  out,  2);
    chk("acc_busy", busy, 1);
    chk("acc_done", done, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("burst_out%0d", k),  out,  lucas_exp[k]);
      chk($sformatf("burst_busy%0d", k), busy, (k < 4) ? 1 : 0);
      chk($sformatf("burst_done%0d", k), done, (k == 4) ? 1 : 0);
    end
    step = 1'b0;
    chk("burst_index", index, 5);
    tick();
    chk("post_done", done, 0);
    chk("post_out",  out,  11);

    // Zero-length burst together with step: no advance, done next cycle
    start = 1'b1; n_terms = 8'd0; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0;
    chk("zero_out",   out,   11);
    chk("zero_index", index, 5);
    chk("zero_busy",  busy,  0);
    chk("zero_done",  done,  1);
    tick();
    chk("zero_done_clr", done, 0);
    chk("zero_busy2",    busy, 0);

    // Reset mid-burst
    start = 1'b1; n_terms = 8'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_out", out, 29);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_out",   out,   0);
    chk("rstmid_busy",  busy,  0);
    chk("rstmid_index", index, 0);
    chk("rstmid_ovf",   ovf,   0);
    chk("rstmid_done",  done,  0);
    tick();
    chk("rstmid_done2", done, 0);
    chk("rstmid_out2",  out,  0);

    // Load mid-burst, after an overflow so the clear of ovf is visible
    load = 1'b1; seed0 = 8'd200; seed1 = 8'd100;
    tick();
    load = 1'b0;
    start = 1'b1; n_terms = 8'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("ldmid_pre_out", out, 44);
    chk("ldmid_pre_ovf", ovf, 1);
    load = 1'b1; seed0 = 8'd7; seed1 = 8'd9;
    tick();
    load = 1'b0;
    chk("ldmid_out",   out,   7);
    chk("ldmid_busy",  busy,  0);
    chk("ldmid_index", index, 0);
    chk("ldmid_ovf",   ovf,   0);
    chk("ldmid_done",  done,  0);
    tick();
    chk("ldmid_done2", done, 0);
    chk("ldmid_out2",  out,  7);

    // Index saturates at all-ones; zero seeds keep the terms at zero
    load = 1'b1; seed0 = 8'd0; seed1 = 8'd0;
    tick();
    load = 1'b0;
    step = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    step = 1'b0;
    chk("idx_sat", index, 255);
    chk("idx_out", out,   0);
    chk("idx_ovf", ovf,   0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
